// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: single-outstanding fetch FSM feeding the IF/ID register,
// with a one-entry skid buffer for words returning while decode is stalled and a
// stale-response flag so wrong-path data after a redirect is dropped.
// Optional feature: define HALT_DETECT_EN to freeze fetch on opcode 6'h3F.
//
// Memory handshake: imem_req is held high with imem_addr stable until a cycle in
// which imem_ack=1; that cycle carries imem_rdata and completes the request. The
// memory may ack in the same cycle req is first raised. A new request is never
// raised while an earlier one (including a stale one) is still unanswered.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [5:0]  instr_op,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic        halted,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    localparam logic [5:0] HALT_OP = 6'h3F;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        stale_q, stale_d;
    logic [31:0] skid_q, skid_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pc_q, if_pc_d;

    logic        load;
    logic [31:0] load_word;

    // Low target bits are forced to zero; they are deliberately not used.
    logic        unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Request only while fetching and no stale response is still owed to us.
    assign imem_req    = (state_q == S_FETCH) && !stale_q;
    assign imem_addr   = pc_q;
    assign if_valid    = if_valid_q;
    assign if_instr    = if_instr_q;
    assign instr_op    = if_instr_q[31:26];
    assign if_pc       = if_pc_q;
    assign if_pc_plus4 = if_pc_q + 32'd4;
    assign dbg_state   = state_q;

`ifdef HALT_DETECT_EN
    assign halted = (state_q == S_HALT);
`else
    assign halted = 1'b0;
`endif

    // Next-state, PC, skid and IF/ID computation; redirect has priority over everything.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        stale_d    = stale_q;
        skid_d     = skid_q;
        if_valid_d = if_valid_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        load       = 1'b0;
        load_word  = 32'h0;

        if (redirect) begin
            state_d    = S_FETCH;
            pc_d       = {redirect_pc[31:2], 2'b00};
            if_valid_d = 1'b0;
            skid_d     = 32'h0;
            // An unanswered request becomes stale; an ack this cycle settles it.
            if (imem_ack) begin
                stale_d = 1'b0;
            end else if (imem_req) begin
                stale_d = 1'b1;
            end
        end else begin
            case (state_q)
                S_FETCH: begin
                    // Decode consumed the current entry unless it is stalled.
                    if (!stall) begin
                        if_valid_d = 1'b0;
                    end
                    if (imem_ack) begin
                        if (stale_q) begin
                            stale_d = 1'b0;
                        end else if (stall) begin
                            skid_d  = imem_rdata;
                            state_d = S_HOLD;
                        end else begin
                            load      = 1'b1;
                            load_word = imem_rdata;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        load      = 1'b1;
                        load_word = skid_q;
                        skid_d    = 32'h0;
                        state_d   = S_FETCH;
                    end
                end
                S_HALT: begin
                    // Frozen: IF/ID keeps the halt word until redirect or reset.
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end

        if (load) begin
            if_valid_d = 1'b1;
            if_instr_d = load_word;
            if_pc_d    = pc_q;
            pc_d       = pc_q + 32'd4;
`ifdef HALT_DETECT_EN
            if (load_word[31:26] == HALT_OP) begin
                state_d = S_HALT;
            end
`endif
        end
    end

    // State register for the FSM, PC, stale flag, skid buffer and IF/ID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            stale_q    <= 1'b0;
            skid_q     <= 32'h0;
            if_valid_q <= 1'b0;
            if_instr_q <= 32'h0;
            if_pc_q    <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            stale_q    <= stale_d;
            skid_q     <= skid_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Testbench for if_fetch_stage: reactive memory model with random latency, a
// program-order reference model feeding an expected queue of {pc, word}, and a
// negedge monitor that pops and compares whenever decode accepts an instruction.
module tb_if_fetch_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] HALT_ADDR = 32'h7000_0000;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [5:0]  instr_op;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        halted;
    logic [1:0]  dbg_state;

    if_fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .instr_op    (instr_op),
        .if_pc       (if_pc),
        .if_pc_plus4 (if_pc_plus4),
        .halted      (halted),
        .dbg_state   (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int          total = 0;
    int          bad   = 0;
    int          pops  = 0;
    logic [63:0] exp_q[$];

    // Reference model: memory in-flight request and expected program order.
    logic        m_busy;
    logic        m_stale;
    logic [31:0] m_addr;
    int          m_cnt;
    logic [31:0] exp_req_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction memory image: a few fixed words, otherwise a hash without opcode 3F.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        logic [31:0] w;
        if (a == 32'h0)            w = 32'h8C01_0004;
        else if (a == 32'h4)       w = 32'h0022_1820;
        else if (a == HALT_ADDR)   w = 32'hFC00_0000;
        else begin
            w = (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
            if (w[31:26] == 6'h3F) w[26] = 1'b0;
        end
        return w;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        #3;
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        m_busy      = 1'b0;
        m_stale     = 1'b0;
        m_addr      = 32'h0;
        m_cnt       = 0;
        exp_req_addr = RESET_PC;
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_imem_req",  {31'h0, imem_req}, 32'h1);
        check("rst_imem_addr", imem_addr, RESET_PC);
        check("rst_if_valid",  {31'h0, if_valid}, 32'h0);
        check("rst_if_instr",  if_instr, 32'h0);
        check("rst_if_pc",     if_pc, 32'h0);
        check("rst_instr_op",  {26'h0, instr_op}, 32'h0);
        check("rst_halted",    {31'h0, halted}, 32'h0);
    endtask

    // One clock: drive stall/redirect and the memory's response for this cycle.
    task automatic cycle(input logic st, input logic rd, input logic [31:0] tgt, input int lat);
        @(posedge clk);
        #1;
        stall       = st;
        redirect    = rd;
        redirect_pc = tgt;
        imem_ack    = 1'b0;
        imem_rdata  = $urandom;
        if (imem_req) begin
            if (!m_busy) begin
                check("req_addr", imem_addr, exp_req_addr);
                m_busy  = 1'b1;
                m_stale = 1'b0;
                m_addr  = imem_addr;
                m_cnt   = lat;
                exp_req_addr = imem_addr + 32'd4;
            end else begin
                check("req_held_addr", imem_addr, m_addr);
            end
        end
        if (rd) begin
            exp_q.delete();
            exp_req_addr = {tgt[31:2], 2'b00};
            if (m_busy) m_stale = 1'b1;
        end
        if (m_busy) begin
            if (m_cnt == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = word_of(m_addr);
                m_busy     = 1'b0;
                if (!m_stale) exp_q.push_back({m_addr, word_of(m_addr)});
            end else begin
                m_cnt--;
            end
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [63:0] e;
        if (rst_n && if_valid && !stall && !redirect) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL mon_extra: got pc %h with empty expected queue", if_pc);
            end else begin
                e = exp_q.pop_front();
                pops++;
                check("mon_pc",     if_pc, e[63:32]);
                check("mon_instr",  if_instr, e[31:0]);
                check("mon_op",     {26'h0, instr_op}, {26'h0, e[31:26]});
                check("mon_plus4",  if_pc_plus4, e[63:32] + 32'd4);
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] p0;
    logic [31:0] i0;

    initial begin
        rst_n = 1'b0;
        do_reset();

        // Back-to-back acks from reset.
        cycle(1'b0, 1'b0, 32'h0, 0);
        cycle(1'b0, 1'b0, 32'h0, 0);
        @(negedge clk);
        check("seq_op0",    {26'h0, instr_op}, 32'h23);
        check("seq_plus4a", if_pc_plus4, 32'h4);
        check("seq_addr1",  imem_addr, 32'h4);
        cycle(1'b0, 1'b0, 32'h0, 0);
        @(negedge clk);
        check("seq_op1",    {26'h0, instr_op}, 32'h00);
        check("seq_plus4b", if_pc_plus4, 32'h8);

        // Three-cycle stall with an ack arriving in the first stalled cycle.
        cycle(1'b1, 1'b0, 32'h0, 0);
        @(negedge clk);
        p0 = if_pc;
        i0 = if_instr;
        for (int k = 0; k < 3; k++) begin
            cycle((k < 2) ? 1'b1 : 1'b0, 1'b0, 32'h0, 0);
            @(negedge clk);
            check("stall_pc",    if_pc, p0);
            check("stall_instr", if_instr, i0);
            check("stall_req",   {31'h0, imem_req}, 32'h0);
        end
        cycle(1'b0, 1'b0, 32'h0, 0);
        @(negedge clk);
        check("unstall_pc",    if_pc, p0 + 32'd4);
        check("unstall_valid", {31'h0, if_valid}, 32'h1);

        // Redirect while a request is pending one cycle before its ack.
        cycle(1'b0, 1'b1, 32'h40, 1);
        cycle(1'b0, 1'b0, 32'h0, 0);
        @(negedge clk);
        check("stale_req_off", {31'h0, imem_req}, 32'h0);
        cycle(1'b0, 1'b0, 32'h0, 0);
        @(negedge clk);
        check("redir_req",  {31'h0, imem_req}, 32'h1);
        check("redir_addr", imem_addr, 32'h40);
        cycle(1'b0, 1'b0, 32'h0, 0);
        @(negedge clk);
        check("redir_if_pc", if_pc, 32'h40);

        // Redirect together with ack and stall.
        cycle(1'b1, 1'b1, 32'h80, 0);
        cycle(1'b0, 1'b0, 32'h0, 0);
        @(negedge clk);
        check("flush_valid", {31'h0, if_valid}, 32'h0);
        check("flush_addr",  imem_addr, 32'h80);

        // PC wrap-around.
        cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 0);
        cycle(1'b0, 1'b0, 32'h0, 0);
        cycle(1'b0, 1'b0, 32'h0, 0);
        @(negedge clk);
        check("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
        check("wrap_plus4", if_pc_plus4, 32'h0);
        check("wrap_addr",  imem_addr, 32'h0);

        // Halt opcode.
        cycle(1'b0, 1'b1, HALT_ADDR, 0);
        cycle(1'b0, 1'b0, 32'h0, 0);
`ifdef HALT_DETECT_EN
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 1'b0, 32'h0, 0);
            @(negedge clk);
            check("halt_flag",  {31'h0, halted}, 32'h1);
            check("halt_req",   {31'h0, imem_req}, 32'h0);
            check("halt_instr", if_instr, 32'hFC00_0000);
        end
        cycle(1'b0, 1'b1, 32'h100, 0);
        cycle(1'b0, 1'b0, 32'h0, 0);
        @(negedge clk);
        check("resume_halted", {31'h0, halted}, 32'h0);
        check("resume_req",    {31'h0, imem_req}, 32'h1);
        check("resume_addr",   imem_addr, 32'h100);
`else
        cycle(1'b0, 1'b0, 32'h0, 0);
        @(negedge clk);
        check("nohalt_instr",  if_instr, 32'hFC00_0000);
        check("nohalt_halted", {31'h0, halted}, 32'h0);
        check("nohalt_req",    {31'h0, imem_req}, 32'h1);
        check("nohalt_addr",   imem_addr, HALT_ADDR + 32'd4);
`endif

        // Reset in the middle of a slow request drops its response.
        cycle(1'b0, 1'b0, 32'h0, 3);
        do_reset();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
                  32'($urandom_range(0, 4095)),
                  int'($urandom_range(0, 3)));
        end
        for (int n = 0; n < 10; n++) begin
            cycle(1'b0, 1'b0, 32'h0, 0);
        end
        @(negedge clk);
        check("consumed_enough", {31'h0, (pops >= 200)}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
